// File: rtl/slave_cmd_pkg.sv
// Shared types and command-code helpers for the SPI slave command FIFO.
// Code words are built at MAX_W bits and truncated by the user to W.
package slave_cmd_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ARMED = 2'd1,
        RD_MODE  = 2'd2
    } state_t;

    function automatic logic [MAX_W-1:0] half_fill(
        input int w,
        input bit upper,
        input bit lower
    );
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (i < w / 2) r[i] = lower;
            else           r[i] = upper;
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] cmd_mem(input int w);
        return half_fill(w, 1'b1, 1'b0);
    endfunction

    function automatic logic [MAX_W-1:0] cmd_leg(input int w);
        return half_fill(w, 1'b0, 1'b1);
    endfunction

    function automatic logic [MAX_W-1:0] cmd_flush(input int w);
        return half_fill(w, 1'b1, 1'b1);
    endfunction

    function automatic logic [MAX_W-1:0] cmd_stat(input int w);
        return half_fill(w, 1'b0, 1'b0);
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Register-based FIFO with separate occupancy counter.
// The head entry is read combinationally so a pop can be answered at once.
module sync_fifo_core #(
    parameter int W     = 20,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap on their own; count disambiguates full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_do_push) begin
            r_wptr  <= r_wptr + 1'b1;
            r_count <= r_count + 1'b1;
        end else if (w_do_pop) begin
            r_rptr  <= r_rptr + 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/slave_cmd_fifo.sv
// Command decoder and reply path between the SPI slave and the word FIFO.
// Received words are registered once, then acted on at the following edge.
module slave_cmd_fifo
    import slave_cmd_pkg::*;
#(
    parameter int           W          = 20,
    parameter int           DEPTH      = 8,
    parameter logic [W-1:0] EMPTY_WORD = {W{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   o_RX_DV,
    input  logic [W-1:0]           o_RX_Byte,
    output logic                   i_TX_DV,
    output logic [W-1:0]           i_TX_Byte,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_ovf,
    output logic                   err_udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [W-1:0] C_MEM   = W'(cmd_mem(W));
    localparam logic [W-1:0] C_LEG   = W'(cmd_leg(W));
    localparam logic [W-1:0] C_FLUSH = W'(cmd_flush(W));
    localparam logic [W-1:0] C_STAT  = W'(cmd_stat(W));

    state_t         r_state;
    logic           r_rx_dv;
    logic [W-1:0]   r_rx_word;

    logic           w_is_mem;
    logic           w_is_leg;
    logic           w_is_flush;
    logic           w_is_stat;
    logic           w_push;
    logic           w_pop;
    logic           w_clear;
    logic [W-1:0]   w_rdata;
    logic [W-1:0]   w_stat_word;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;

    assign w_is_mem   = (r_rx_word == C_MEM);
    assign w_is_leg   = (r_rx_word == C_LEG);
    assign w_is_flush = (r_rx_word == C_FLUSH);
    assign w_is_stat  = (r_rx_word == C_STAT);

    assign w_push  = r_rx_dv && (r_state == WR_ARMED);
    assign w_pop   = r_rx_dv && (r_state == RD_MODE);
    assign w_clear = r_rx_dv && (r_state == IDLE) && w_is_flush;

    assign full  = w_full;
    assign empty = w_empty;
    assign count = w_count;

    always_comb begin
        w_stat_word         = '0;
        w_stat_word[W-1]    = err_ovf;
        w_stat_word[W-2]    = err_udf;
        w_stat_word[CW-1:0] = w_count;
    end

    sync_fifo_core #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_wdata (r_rx_word),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_dv   <= 1'b0;
            r_rx_word <= '0;
        end else begin
            r_rx_dv   <= o_RX_DV;
            if (o_RX_DV) begin
                r_rx_word <= o_RX_Byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            i_TX_DV   <= 1'b0;
            i_TX_Byte <= '0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
        end else begin
            i_TX_DV <= 1'b0;
            if (r_rx_dv) begin
                unique case (r_state)
                    IDLE: begin
                        unique case (1'b1)
                            w_is_mem: r_state <= WR_ARMED;
                            w_is_leg: r_state <= RD_MODE;
                            w_is_flush: begin
                                err_ovf <= 1'b0;
                                err_udf <= 1'b0;
                            end
                            w_is_stat: begin
                                i_TX_DV   <= 1'b1;
                                i_TX_Byte <= w_stat_word;
                            end
                            default: ;
                        endcase
                    end
                    WR_ARMED: begin
                        if (w_full) begin
                            err_ovf <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    RD_MODE: begin
                        i_TX_DV <= 1'b1;
                        if (w_empty) begin
                            i_TX_Byte <= EMPTY_WORD;
                            err_udf   <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            i_TX_Byte <= w_rdata;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slave_cmd_fifo.sv
// Scoreboard bench for slave_cmd_fifo (W=20, DEPTH=8).
// Expected replies are queued by the driver and checked by the monitor.
module tb_slave_cmd_fifo;

    localparam int W = 20;
    localparam logic [W-1:0] MEM   = 20'hFFC00;
    localparam logic [W-1:0] LEG   = 20'h003FF;
    localparam logic [W-1:0] FLUSH = 20'hFFFFF;
    localparam logic [W-1:0] STAT  = 20'h00000;

    logic         clk = 1'b0;
    logic         rst;
    logic         o_RX_DV;
    logic [W-1:0] o_RX_Byte;
    logic         i_TX_DV;
    logic [W-1:0] i_TX_Byte;
    logic         full;
    logic         empty;
    logic [3:0]   count;
    logic         err_ovf;
    logic         err_udf;

    logic [W-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    slave_cmd_fifo #(.W(W), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .o_RX_DV   (o_RX_DV),
        .o_RX_Byte (o_RX_Byte),
        .i_TX_DV   (i_TX_DV),
        .i_TX_Byte (i_TX_Byte),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b1 && i_TX_DV === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL reply: got unexpected %h, required none", i_TX_Byte);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (i_TX_Byte !== e) begin
                    bad++;
                    $display("FAIL reply: got %h, required %h", i_TX_Byte, e);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        @(negedge clk);
        o_RX_DV   = 1'b1;
        o_RX_Byte = w;
        @(negedge clk);
        o_RX_DV   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_reply(input logic [W-1:0] w);
        exp_q.push_back(w);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        rst       = 1'b0;
        o_RX_DV   = 1'b0;
        o_RX_Byte = '0;
        #1;
        chk("rst_txdv", 32'(i_TX_DV), 32'd0);
        chk("rst_txbyte", 32'(i_TX_Byte), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", 32'({err_ovf, err_udf}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        send(MEM); send(20'hA275B);
        chk("basic_cnt1", 32'(count), 32'd1);
        send(MEM); send(20'hA775B);
        chk("basic_cnt2", 32'(count), 32'd2);
        send(LEG);
        expect_reply(20'hA275B); send(20'h0);
        chk("basic_pop1", 32'(count), 32'd1);
        expect_reply(20'hA775B); send(20'h0);
        chk("basic_pop2", 32'(count), 32'd0);
        expect_reply(20'h0); send(20'h0);
        chk("basic_udf", 32'(err_udf), 32'd1);

        send(MEM); send(MEM);
        send(MEM); send(LEG);
        chk("codes_cnt", 32'(count), 32'd2);
        send(LEG);
        expect_reply(20'hFFC00); send(20'h0);
        expect_reply(20'h003FF); send(20'h0);
        expect_reply(20'h0); send(20'h0);

        send(MEM); send(20'h11111);
        send(20'h0AAAB);
        chk("data_ignored", 32'(count), 32'd1);
        send(FLUSH);
        chk("flush_cnt", 32'(count), 32'd0);
        chk("flush_udf", 32'(err_udf), 32'd0);

        for (int i = 1; i <= 9; i++) begin
            send(MEM); send(W'(i));
            if (i == 8) chk("ovf_full8", 32'(full), 32'd1);
        end
        chk("ovf_flag", 32'(err_ovf), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd8);
        expect_reply(20'h80008); send(STAT);
        send(LEG);
        for (int i = 1; i <= 8; i++) begin
            expect_reply(W'(i));
            send(20'h5A5A5);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        expect_reply(20'h0); send(20'h0);
        send(FLUSH);
        expect_reply(20'h00000); send(STAT);
        chk("fs_empty", 32'(empty), 32'd1);
        chk("fs_flags", 32'({err_ovf, err_udf}), 32'd0);

        send(MEM); send(20'h00001);
        send(MEM); send(20'h00002);
        send(MEM); send(20'h00003);
        send(LEG);
        expect_reply(20'h00001); send(20'h0);
        chk("mid_cnt", 32'(count), 32'd2);
        @(negedge clk);
        o_RX_DV   = 1'b1;
        o_RX_Byte = 20'h0;
        @(posedge clk);
        #2;
        rst     = 1'b0;
        o_RX_DV = 1'b0;
        #1;
        chk("arst_txdv", 32'(i_TX_DV), 32'd0);
        chk("arst_txbyte", 32'(i_TX_Byte), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send(20'h12345);
        chk("post_cnt", 32'(count), 32'd0);
        send(MEM); send(20'h55555);
        chk("post_idle", 32'(count), 32'd1);

        repeat (5) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending: got %0d replies outstanding, required 0",
                     exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave_cmd_fifo.md
Name: slave_cmd_fifo

Overview:
- Command-driven FIFO behind the SPI slave.
- Consumes received words (o_RX_DV / o_RX_Byte) and decodes a small command set: MEM (store next word), LEG (stream stored words back), FLUSH and STAT.
- Replies go out on i_TX_DV / i_TX_Byte to the SPI slave transmitter.
- Parametrised successor of the fixed 20-bit slave FIFO. Adds configurable width and depth, flush, status query, and sticky overflow/underflow flags.

Parameters:
- W, 20: word width. Must be even and at least $clog2(DEPTH)+3.
- DEPTH, 8: FIFO entries. Must be a power of 2, at least 2.
- EMPTY_WORD, {W{1'b0}}: reply word sent when a read hits an empty FIFO.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- o_RX_DV  input  1  one-cycle strobe: received word valid.
- o_RX_Byte  input  W  received word, sampled when o_RX_DV=1.
- i_TX_DV  output  1  one-cycle strobe: reply word valid.
- i_TX_Byte  output  W  reply word, held until the next reply.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- count  output  $clog2(DEPTH)+1  stored entries.
- err_ovf  output  1  sticky: a write was dropped because the FIFO was full.
- err_udf  output  1  sticky: a read was attempted on an empty FIFO.

Behaviour:
- Command codes, with H=W/2:
  - MEM = {H ones, H zeros}
  - LEG = {H zeros, H ones}
  - FLUSH = {H ones, H ones}
  - STAT = {H zeros, H zeros}
- Reset (rst=0, asynchronous):
  - state=IDLE, pointers=0, count=0.
  - i_TX_DV=0, i_TX_Byte=0.
  - err_ovf=0, err_udf=0, empty=1, full=0.
  - Reset asserted mid-operation discards the FIFO contents and any armed or read mode.
- The block acts only on cycles with o_RX_DV=1. Other cycles hold state, and i_TX_DV is 0.
- State machine (IDLE, WR_ARMED, RD_MODE):
  - IDLE, word=MEM -> WR_ARMED.
  - IDLE, word=LEG -> RD_MODE. No reply is sent.
  - IDLE, word=FLUSH -> pointers, count, err_ovf and err_udf cleared. Stay in IDLE.
  - IDLE, word=STAT -> reply {err_ovf, err_udf, zero pad, count}. Stay in IDLE.
  - IDLE, any other word -> ignored, with no reply and no state change.
  - WR_ARMED, any word (including a command code) -> stored verbatim, then -> IDLE.
    - If full: word dropped, err_ovf=1, -> IDLE.
  - RD_MODE, any word (the content is don't-care) -> reads one entry.
    - Not empty: pop the head and reply with it. Stay in RD_MODE. Popping the last entry does not leave RD_MODE.
    - Empty: reply EMPTY_WORD, err_udf=1, -> IDLE.
- Latency:
  - A strobe sampled at edge n produces i_TX_DV=1 for exactly the cycle after edge n+1.
  - A write is visible in count after edge n+1.
- Pointers: ADDR_W=$clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0. count is tracked separately, so full and empty are unambiguous.
- Push and pop never coincide, because there is one input stream.
- Storage is registered. The read head is available combinationally from the memory, so the reply needs no extra wait cycle.

Decomposition:
- Package slave_cmd_pkg:
  - state enum (IDLE, WR_ARMED, RD_MODE).
  - functions cmd_mem(W), cmd_leg(W), cmd_flush(W), cmd_stat(W) returning the code words.
- Sub-module sync_fifo_core:
  - storage array, pointers, count, full/empty, push/pop.
  - parameters W and DEPTH, same clk/rst.
- The top level holds the decoder, FSM and TX register.

Test Plan (W=20, DEPTH=8):
- Basic write then read:
  - Stimulus: MEM, 0xA275B, MEM, 0xA775B, LEG, 3 strobes.
  - Response: replies 0xA275B, 0xA775B, then EMPTY_WORD with err_udf=1. State returns to IDLE; count 2->1->0.
- Command codes stored as data:
  - Stimulus: MEM,MEM then MEM,LEG, then LEG and 2 strobes.
  - Response: replies 0xFFC00 then 0x003FF. No mode change while in WR_ARMED.
- Data outside a command:
  - Stimulus: 0x0AAAB in IDLE.
  - Response: no i_TX_DV, count unchanged.
  - Stimulus: 0xFFFFF alone.
  - Response: FLUSH; count=0.
- Overflow:
  - Stimulus: 9 MEM+data pairs (values 1..9).
  - Response: full=1 after the 8th; 9th dropped; err_ovf=1. STAT replies 0x80008. LEG reads return 1..8 in order, with pointer wrap checked.
- Flush and status:
  - Stimulus: after the overflow case, send FLUSH, then STAT.
  - Response: STAT reply 0x00000, empty=1, both error flags 0.
- Reset mid-operation:
  - Stimulus: store 3 words, enter RD_MODE, pop 1, assert rst=0 asynchronously between edges.
  - Response: all outputs at reset values immediately. After release, a strobe in IDLE with 0x12345 is ignored.
